// File: rtl/pipe_rx_data_packer.sv
// rtl/pipe_rx_data_packer.sv - packs PIPE receive symbols into 32-bit words for the descrambler
module pipe_rx_data_packer #(
    parameter int pipe_width_gen1 = 8,
    parameter int pipe_width_gen2 = 8,
    parameter int pipe_width_gen3 = 16,
    parameter int pipe_width_gen4 = 32,
    parameter int pipe_width_gen5 = 32
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic [2:0]  generation,
    input  logic [31:0] RxData,
    input  logic [3:0]  RxDataK,
    input  logic        RxValid,
    output logic [31:0] descramblerDataIn,
    output logic [3:0]  descramblerDataK,
    output logic [3:0]  descramblerDataValid,
    output logic        partialDrop
);

    localparam logic [2:0] syms_gen1 = 3'(pipe_width_gen1 / 8);
    localparam logic [2:0] syms_gen2 = 3'(pipe_width_gen2 / 8);
    localparam logic [2:0] syms_gen3 = 3'(pipe_width_gen3 / 8);
    localparam logic [2:0] syms_gen4 = 3'(pipe_width_gen4 / 8);
    localparam logic [2:0] syms_gen5 = 3'(pipe_width_gen5 / 8);

    logic [31:0] acc_data, acc_data_n, merged_data, out_data_n;
    logic [3:0]  acc_k, acc_k_n, merged_k, out_k_n, out_valid_n, flush_mask;
    logic [2:0]  fill, fill_n, gen_q, syms, base, pos;
    logic        drop;

    always_comb begin
        case (generation)
            3'd1:    syms = syms_gen1;
            3'd2:    syms = syms_gen2;
            3'd3:    syms = syms_gen3;
            3'd4:    syms = syms_gen4;
            3'd5:    syms = syms_gen5;
            default: syms = 3'd0;
        endcase
    end

    always_comb begin
        case (fill)
            3'd1:    flush_mask = 4'b0001;
            3'd2:    flush_mask = 4'b0011;
            3'd3:    flush_mask = 4'b0111;
            default: flush_mask = 4'b0000;
        endcase
    end

    always_comb begin
        // An invalid generation while holding bytes is treated like a generation change.
        drop = (fill != 3'd0) && ((generation != gen_q) || (syms == 3'd0));
        base = drop ? 3'd0 : fill;

        merged_data = drop ? 32'd0 : acc_data;
        merged_k    = drop ? 4'd0 : acc_k;
        pos         = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pos = base + 3'(i);
            if ((3'(i) < syms) && (pos < 3'd4)) begin
                merged_data[{pos[1:0], 3'b000} +: 8] = RxData[i*8 +: 8];
                merged_k[pos[1:0]]                   = RxDataK[i];
            end
        end

        acc_data_n  = drop ? 32'd0 : acc_data;
        acc_k_n     = drop ? 4'd0 : acc_k;
        fill_n      = base;
        out_data_n  = 32'd0;
        out_k_n     = 4'd0;
        out_valid_n = 4'd0;

        if (syms == 3'd0) begin
            fill_n     = 3'd0;
            acc_data_n = 32'd0;
            acc_k_n    = 4'd0;
        end else if (RxValid) begin
            if (base + syms == 3'd4) begin
                out_data_n  = merged_data;
                out_k_n     = merged_k;
                out_valid_n = 4'hF;
                fill_n      = 3'd0;
                acc_data_n  = 32'd0;
                acc_k_n     = 4'd0;
            end else begin
                acc_data_n = merged_data;
                acc_k_n    = merged_k;
                fill_n     = base + syms;
            end
        end else if (base != 3'd0) begin
            out_valid_n = flush_mask;
            out_k_n     = acc_k & flush_mask;
            for (int i = 0; i < 4; i++) begin
                if (flush_mask[i]) out_data_n[i*8 +: 8] = acc_data[i*8 +: 8];
            end
            fill_n     = 3'd0;
            acc_data_n = 32'd0;
            acc_k_n    = 4'd0;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            acc_data             <= 32'd0;
            acc_k                <= 4'd0;
            fill                 <= 3'd0;
            gen_q                <= 3'd0;
            descramblerDataIn    <= 32'd0;
            descramblerDataK     <= 4'd0;
            descramblerDataValid <= 4'd0;
            partialDrop          <= 1'b0;
        end else begin
            acc_data             <= acc_data_n;
            acc_k                <= acc_k_n;
            fill                 <= fill_n;
            gen_q                <= generation;
            descramblerDataIn    <= out_data_n;
            descramblerDataK     <= out_k_n;
            descramblerDataValid <= out_valid_n;
            partialDrop          <= drop;
        end
    end

endmodule
